fwd_hazard_ctrl: RTL and testbench
==================================

Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the RV32IM pipeline.
- Tracks destination registers of in-flight instructions (EX, MEM, WB slots) and produces the registered 2-bit selects for the two EX-stage 32-bit 4-input operand muxes (A and B).
- Generates load-use and multi-cycle MUL/DIV stalls and bubbles.
- Sits alongside the ID/EX pipeline register.

Parameters:
- DIV_CYCLES, 32, total cycles a DIV/REM instruction occupies EX; minimum 1.
- CNT_W, 6, width of the busy counter; must hold DIV_CYCLES-1.

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- ID_RS1  input  5  rs1 of instruction in ID
- ID_RS2  input  5  rs2 of instruction in ID
- ID_RS1_USED  input  1  instruction in ID reads rs1
- ID_RS2_USED  input  1  instruction in ID reads rs2
- ID_RD  input  5  rd of instruction in ID
- ID_REG_WRITE  input  1  instruction in ID writes rd
- ID_IS_LOAD  input  1  instruction in ID is a load
- ID_IS_DIV  input  1  instruction in ID is DIV/DIVU/REM/REMU
- FLUSH  input  1  branch/jump taken in EX; kill instruction in ID
- FWD_SEL_A  output  2  operand A mux select, valid for instruction in EX
- FWD_SEL_B  output  2  operand B mux select, valid for instruction in EX
- STALL  output  1  hold PC, IF/ID and ID/EX (combinational)
- ID_EX_BUBBLE  output  1  load invalid into ID/EX this edge (combinational)
- EX_MEM_BUBBLE  output  1  load invalid into EX/MEM this edge (combinational)

Behaviour:
- Select encoding (fixed by mux wiring):
  - 00 = register-file value
  - 10 = EX/MEM ALU result
  - 11 = MEM/WB writeback value
  - 01 = post-WB holding register, the value written one cycle earlier
- Tracking slots EXS, MEMS, WBS, each holding {valid, rd, reg_write, is_load}.
- A match requires: slot valid, reg_write=1, rd!=0, rd==rs, and the matching USED bit=1.
- Source selection is computed in ID against the slots, then registered into FWD_SEL_* when ID advances. Priority, youngest first:
  - EXS match -> 10
  - else MEMS match -> 11
  - else WBS match -> 01
  - else 00
- Load-use: EXS.is_load and an EXS match on a used operand gives:
  - STALL=1 and ID_EX_BUBBLE=1.
  - At the edge: EXS<-invalid, MEMS<-EXS, WBS<-MEMS, FWD_SEL_* <- 00.
  - The next cycle recomputes, so the load then matches MEMS and selects 11.
- Normal advance (no stall, state RUN):
  - EXS<-{1,ID_RD,ID_REG_WRITE,ID_IS_LOAD}, MEMS<-EXS, WBS<-MEMS.
  - FWD_SEL_* <- computed values.
- FLUSH=1 in RUN:
  - ID_EX_BUBBLE=1, EXS<-invalid, FWD_SEL_* <- 00. Shift of MEMS and WBS proceeds.
  - FLUSH overrides load-use; STALL=0.
- State machine, states RUN and DIV_BUSY:
  - RUN -> DIV_BUSY when a DIV instruction advances from ID with DIV_CYCLES>1; cnt <- DIV_CYCLES-1.
  - In DIV_BUSY: STALL=1, EX_MEM_BUBBLE=1, ID_EX_BUBBLE=0. EXS and FWD_SEL_* are held; MEMS<-invalid, WBS<-MEMS. cnt decrements each cycle.
  - DIV_BUSY -> RUN on the edge where cnt goes 1->0. This gives exactly DIV_CYCLES-1 stall cycles.
  - Load-use is not evaluated and FLUSH is ignored in DIV_BUSY.
- A load-use check in RUN takes priority over DIV issue: a stalled DIV does not start the counter.
- Reset (synchronous; wins over all other inputs, including mid-DIV_BUSY):
  - state=RUN, cnt=0, all slots invalid, FWD_SEL_A=FWD_SEL_B=00.
  - STALL, ID_EX_BUBBLE and EX_MEM_BUBBLE read 0 in the cycle after reset.
- rd=x0 never forwards. Unused rs never stalls.

Test Plan:
- add x5 (ID), next addi x6,x5,1 -> FWD_SEL_A=10 in EX cycle; FWD_SEL_B=00 (rs2 unused).
- Writers x7 at distances 2 and 3 before reader of x7 in rs1, rs2 -> distance 2: FWD_SEL_A=11; distance 3: FWD_SEL_B=01. Two writers of x7 at distances 1 and 2 -> 10 (youngest wins).
- lw x8 then add x9,x8,x8 -> STALL=1 and ID_EX_BUBBLE=1 for 1 cycle, then FWD_SEL_A=FWD_SEL_B=11; with rd=x0 -> no stall, selects 00.
- div x10 with DIV_CYCLES=4 -> STALL=1 and EX_MEM_BUBBLE=1 for exactly 3 cycles; FWD_SEL_* held; dependent follower then gets 10.
- FLUSH coincident with load-use condition -> STALL=0, ID_EX_BUBBLE=1, FWD_SEL_*=00.
- RESET asserted in 2nd DIV_BUSY cycle -> next cycle STALL=0, selects 00; a reader of prior rd gets 00.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl -- forwarding and hazard controller for the RV32IM pipeline.
//
// Keeps a small record of the destination registers of the instructions in
// EX, MEM and WB.  The instruction in ID is compared against that record to
// choose the operand A/B sources, and the choice is registered when the
// instruction moves into EX.  The same comparison detects load-use hazards.
// A two-state FSM holds the pipe while a multi-cycle DIV/REM occupies EX.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal flow; ID advances unless load-use hazard
// DIV_BUSY | DIV/REM occupying EX; front of pipe held, bubbles into MEM
//
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   ID_RS1/RS2, ID_RS*_USED    source registers of the ID instruction
//   ID_RD, ID_REG_WRITE        destination of the ID instruction
//   ID_IS_LOAD, ID_IS_DIV      instruction class of the ID instruction
//   FLUSH                      taken branch/jump in EX, kill ID
//   FWD_SEL_A/B                registered operand mux selects for EX
//                              (00 regfile, 10 EX/MEM, 11 MEM/WB, 01 post-WB)
//   STALL                      hold PC, IF/ID and ID/EX
//   ID_EX_BUBBLE               load invalid into ID/EX this edge
//   EX_MEM_BUBBLE              load invalid into EX/MEM this edge

module fwd_hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [4:0] ID_RS1,
    input  logic [4:0] ID_RS2,
    input  logic       ID_RS1_USED,
    input  logic       ID_RS2_USED,
    input  logic [4:0] ID_RD,
    input  logic       ID_REG_WRITE,
    input  logic       ID_IS_LOAD,
    input  logic       ID_IS_DIV,
    input  logic       FLUSH,
    output logic [1:0] FWD_SEL_A,
    output logic [1:0] FWD_SEL_B,
    output logic       STALL,
    output logic       ID_EX_BUBBLE,
    output logic       EX_MEM_BUBBLE
);

    typedef enum logic {RUN = 1'b0, DIV_BUSY = 1'b1} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
    } slot_t;

    localparam logic [1:0] SEL_RF   = 2'b00;
    localparam logic [1:0] SEL_EXM  = 2'b10;
    localparam logic [1:0] SEL_MWB  = 2'b11;
    localparam logic [1:0] SEL_HOLD = 2'b01;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_t            exs_q, exs_d;
    slot_t            mems_q, mems_d;
    slot_t            wbs_q, wbs_d;
    logic [1:0]       sel_a_q, sel_a_d;
    logic [1:0]       sel_b_q, sel_b_d;

    logic [1:0] src_a, src_b;
    logic       exs_hit_a, exs_hit_b;
    logic       load_use;

    function automatic logic slot_match(slot_t s, logic [4:0] rs, logic used);
        return s.valid && s.reg_write && (s.rd != 5'd0) && (s.rd == rs) && used;
    endfunction

    function automatic logic [1:0] pick_src(slot_t ex, slot_t mem, slot_t wb,
                                            logic [4:0] rs, logic used);
        if (slot_match(ex, rs, used))       return SEL_EXM;
        else if (slot_match(mem, rs, used)) return SEL_MWB;
        else if (slot_match(wb, rs, used))  return SEL_HOLD;
        else                                return SEL_RF;
    endfunction

    always_comb begin
        src_a     = pick_src(exs_q, mems_q, wbs_q, ID_RS1, ID_RS1_USED);
        src_b     = pick_src(exs_q, mems_q, wbs_q, ID_RS2, ID_RS2_USED);
        exs_hit_a = slot_match(exs_q, ID_RS1, ID_RS1_USED);
        exs_hit_b = slot_match(exs_q, ID_RS2, ID_RS2_USED);
        load_use  = exs_q.is_load && (exs_hit_a || exs_hit_b);
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        exs_d         = exs_q;
        mems_d        = mems_q;
        wbs_d         = wbs_q;
        sel_a_d       = sel_a_q;
        sel_b_d       = sel_b_q;
        STALL         = 1'b0;
        ID_EX_BUBBLE  = 1'b0;
        EX_MEM_BUBBLE = 1'b0;

        case (state_q)
            RUN: begin
                mems_d = exs_q;
                wbs_d  = mems_q;
                // FLUSH kills the ID instruction, so a hazard it would have
                // caused no longer matters.
                if (FLUSH || load_use) begin
                    STALL        = !FLUSH;
                    ID_EX_BUBBLE = 1'b1;
                    exs_d        = '0;
                    sel_a_d      = SEL_RF;
                    sel_b_d      = SEL_RF;
                end else begin
                    exs_d   = '{valid: 1'b1, rd: ID_RD, reg_write: ID_REG_WRITE,
                                is_load: ID_IS_LOAD};
                    sel_a_d = src_a;
                    sel_b_d = src_b;
                    if (ID_IS_DIV && (DIV_CYCLES > 1)) begin
                        state_d = DIV_BUSY;
                        cnt_d   = CNT_W'(DIV_CYCLES - 1);
                    end
                end
            end
            DIV_BUSY: begin
                // DIV stays in EX with its selects; MEM receives bubbles.
                STALL         = 1'b1;
                EX_MEM_BUBBLE = 1'b1;
                mems_d        = '0;
                wbs_d         = mems_q;
                cnt_d         = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= RUN;
            cnt_q   <= '0;
            exs_q   <= '0;
            mems_q  <= '0;
            wbs_q   <= '0;
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exs_q   <= exs_d;
            mems_q  <= mems_d;
            wbs_q   <= wbs_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign FWD_SEL_A = sel_a_q;
    assign FWD_SEL_B = sel_b_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl -- directed-vector bench for fwd_hazard_ctrl
// (DIV_CYCLES = 4).  Inputs change 1 ns after the rising edge; combinational
// outputs are sampled 1 ns later, registered outputs right after the edge.

module tb_fwd_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [4:0] ID_RS1, ID_RS2, ID_RD;
    logic       ID_RS1_USED, ID_RS2_USED, ID_REG_WRITE, ID_IS_LOAD, ID_IS_DIV;
    logic       FLUSH;
    logic [1:0] FWD_SEL_A, FWD_SEL_B;
    logic       STALL, ID_EX_BUBBLE, EX_MEM_BUBBLE;

    int n_tests = 0;
    int n_fail  = 0;

    fwd_hazard_ctrl #(.DIV_CYCLES(4), .CNT_W(6)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ID_RS1       (ID_RS1),
        .ID_RS2       (ID_RS2),
        .ID_RS1_USED  (ID_RS1_USED),
        .ID_RS2_USED  (ID_RS2_USED),
        .ID_RD        (ID_RD),
        .ID_REG_WRITE (ID_REG_WRITE),
        .ID_IS_LOAD   (ID_IS_LOAD),
        .ID_IS_DIV    (ID_IS_DIV),
        .FLUSH        (FLUSH),
        .FWD_SEL_A    (FWD_SEL_A),
        .FWD_SEL_B    (FWD_SEL_B),
        .STALL        (STALL),
        .ID_EX_BUBBLE (ID_EX_BUBBLE),
        .EX_MEM_BUBBLE(EX_MEM_BUBBLE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // rs1, used1, rs2, used2, rd, reg_write, is_load, is_div
    task automatic set_id(input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rw,
                          input logic ld, input logic dv);
        ID_RS1 = rs1; ID_RS1_USED = u1;
        ID_RS2 = rs2; ID_RS2_USED = u2;
        ID_RD = rd; ID_REG_WRITE = rw; ID_IS_LOAD = ld; ID_IS_DIV = dv;
    endtask

    task automatic set_nop();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_ctl(input string tag, input logic st, input logic ieb,
                             input logic emb);
        #1;
        check({tag, "_stall"},  8'(STALL),         8'(st));
        check({tag, "_idex"},   8'(ID_EX_BUBBLE),  8'(ieb));
        check({tag, "_exmem"},  8'(EX_MEM_BUBBLE), 8'(emb));
    endtask

    initial begin
        RESET = 1'b1;
        FLUSH = 1'b0;
        set_nop();
        step();
        step();
        RESET = 1'b0;
        check("rst_sel_a", 8'(FWD_SEL_A), 8'h0);
        check("rst_sel_b", 8'(FWD_SEL_B), 8'h0);
        check_ctl("rst", 1'b0, 1'b0, 1'b0);

        // add x5 ; addi x6,x5,1 (rs2 names x5 but is unused)
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        step();
        set_id(5'd5, 1'b1, 5'd5, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
        check_ctl("dep1", 1'b0, 1'b0, 1'b0);
        step();
        check("dep1_a", 8'(FWD_SEL_A), 8'h2);
        check("dep1_b", 8'(FWD_SEL_B), 8'h0);

        // writer x7, nop, reader rs1=x7 (dist 2), reader rs2=x7 (dist 3)
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        step();
        set_nop();
        step();
        set_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        step();
        check("dist2_a", 8'(FWD_SEL_A), 8'h3);
        check("dist2_b", 8'(FWD_SEL_B), 8'h0);
        set_id(5'd0, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        check("dist3_a", 8'(FWD_SEL_A), 8'h0);
        check("dist3_b", 8'(FWD_SEL_B), 8'h1);

        // two writers of x7 then reader: youngest wins
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        step();
        step();
        set_id(5'd7, 1'b1, 5'd7, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        step();
        check("young_a", 8'(FWD_SEL_A), 8'h2);
        check("young_b", 8'(FWD_SEL_B), 8'h2);

        // lw x8 ; add x9,x8,x8 -> one stall, then 11/11
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        step();
        set_id(5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        check_ctl("lu", 1'b1, 1'b1, 1'b0);
        step();
        check("lu_bub_a", 8'(FWD_SEL_A), 8'h0);
        check_ctl("lu_after", 1'b0, 1'b0, 1'b0);
        step();
        check("lu_fwd_a", 8'(FWD_SEL_A), 8'h3);
        check("lu_fwd_b", 8'(FWD_SEL_B), 8'h3);

        // lw x0 ; reader of x0 -> no stall, selects 00
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        step();
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        check_ctl("x0", 1'b0, 1'b0, 1'b0);
        step();
        check("x0_a", 8'(FWD_SEL_A), 8'h0);
        check("x0_b", 8'(FWD_SEL_B), 8'h0);

        // lw x8 ; instruction naming x8 but not reading it -> no stall
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        step();
        set_id(5'd8, 1'b0, 5'd8, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        check_ctl("unused", 1'b0, 1'b0, 1'b0);
        step();

        // writer x12 ; div x10,x12 ; dependent add on x10
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
        step();
        set_id(5'd12, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b1);
        step();
        set_id(5'd10, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_ctl($sformatf("div_busy%0d", i), 1'b1, 1'b0, 1'b1);
            check($sformatf("div_hold_a%0d", i), 8'(FWD_SEL_A), 8'h2);
            step();
        end
        check_ctl("div_done", 1'b0, 1'b0, 1'b0);
        step();
        check("div_fol_a", 8'(FWD_SEL_A), 8'h2);
        check("div_fol_b", 8'(FWD_SEL_B), 8'h0);

        // FLUSH together with a load-use hazard
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        step();
        set_id(5'd8, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        FLUSH = 1'b1;
        check_ctl("flush", 1'b0, 1'b1, 1'b0);
        step();
        FLUSH = 1'b0;
        check("flush_a", 8'(FWD_SEL_A), 8'h0);
        check("flush_b", 8'(FWD_SEL_B), 8'h0);

        // reset in the second DIV_BUSY cycle
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b1);
        step();
        set_nop();
        step();
        check_ctl("div2", 1'b1, 1'b0, 1'b1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        set_id(5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_ctl("rst_div", 1'b0, 1'b0, 1'b0);
        check("rst_div_a", 8'(FWD_SEL_A), 8'h0);
        step();
        check("rst_rd_a", 8'(FWD_SEL_A), 8'h0);
        check("rst_rd_b", 8'(FWD_SEL_B), 8'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
